// File: rtl/sub16_if.sv
// sub16_if: operand/result bundle for the serial 16-bit subtractor.
// The ovf16 signal exists only when SUB16_OVERFLOW_EN is defined.
interface sub16_if;
    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        bin16;
    logic        busy16;
    logic        done16;
    logic [15:0] diff16;
    logic        borrow16;
`ifdef SUB16_OVERFLOW_EN
    logic        ovf16;

    modport master (
        output start16, a16, b16, bin16,
        input  busy16, done16, diff16, borrow16, ovf16
    );

    modport slave (
        input  start16, a16, b16, bin16,
        output busy16, done16, diff16, borrow16, ovf16
    );
`else
    modport master (
        output start16, a16, b16, bin16,
        input  busy16, done16, diff16, borrow16
    );

    modport slave (
        input  start16, a16, b16, bin16,
        output busy16, done16, diff16, borrow16
    );
`endif
endinterface

// File: rtl/sub16_serial.sv
// sub16_serial: 16-bit subtractor computing a - b - bin one nibble per
// clock, LSB nibble first, as a + ~b + carry with initial carry = ~bin.
// Optional feature: define SUB16_OVERFLOW_EN to add the signed overflow
// flag ovf16; without it the flag and its logic are absent.
module sub16_serial (
    input  logic clk,
    input  logic rst,
    sub16_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        accept;
    logic [1:0]  idx_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        carry_q;
    logic [11:0] diff_acc;
    logic [4:0]  nib_sum;
    logic [15:0] diff_q;
    logic        borrow_q;
`ifdef SUB16_OVERFLOW_EN
    logic        ovf_q;
`endif

    // A start is taken whenever no subtraction is running.
    assign accept = bus.start16 && (state != CALC);

    // The operands shift right each step, so the active nibble is always [3:0].
    assign nib_sum = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0000, carry_q};

    assign bus.diff16   = diff_q;
    assign bus.borrow16 = borrow_q;
`ifdef SUB16_OVERFLOW_EN
    assign bus.ovf16    = ovf_q;
`endif

    // State register; reset aborts any subtraction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: four CALC cycles, then a single DONE cycle unless restarted.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? CALC : IDLE;
            CALC:    state_nx = (idx_q == 2'd3) ? DONE : CALC;
            DONE:    state_nx = accept ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decode directly from the state.
    always_comb begin
        bus.busy16 = 1'b0;
        bus.done16 = 1'b0;
        case (state)
            CALC:    bus.busy16 = 1'b1;
            DONE:    bus.done16 = 1'b1;
            default: begin
                bus.busy16 = 1'b0;
                bus.done16 = 1'b0;
            end
        endcase
    end

    // Datapath: latch operands on accept, ripple one nibble per CALC cycle,
    // and publish the results only when the last nibble completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= 2'd0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            carry_q  <= 1'b0;
            diff_acc <= 12'h000;
            diff_q   <= 16'h0000;
            borrow_q <= 1'b0;
`ifdef SUB16_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else if (accept) begin
            idx_q    <= 2'd0;
            a_q      <= bus.a16;
            b_q      <= bus.b16;
            carry_q  <= ~bus.bin16;
            diff_acc <= 12'h000;
        end else if (state == CALC) begin
            idx_q    <= idx_q + 2'd1;
            a_q      <= {4'h0, a_q[15:4]};
            b_q      <= {4'h0, b_q[15:4]};
            carry_q  <= nib_sum[4];
            diff_acc <= {nib_sum[3:0], diff_acc[11:4]};
            if (idx_q == 2'd3) begin
                diff_q   <= {nib_sum[3:0], diff_acc};
                borrow_q <= ~nib_sum[4];
`ifdef SUB16_OVERFLOW_EN
                ovf_q    <= (a_q[3] != b_q[3]) && (nib_sum[3] != a_q[3]);
`endif
            end
        end
    end

endmodule

// File: doc/sub16_serial.md
SUB16_SERIAL -- requirements
Module: sub16_serial

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port start16, input, 1 bit: operand-valid request.
REQ-004 The block SHALL have port a16, input, 16 bits: minuend.
REQ-005 The block SHALL have port b16, input, 16 bits: subtrahend.
REQ-006 The block SHALL have port bin16, input, 1 bit: borrow-in.
REQ-007 The block SHALL have port busy16, output, 1 bit: high while a subtraction is in progress.
REQ-008 The block SHALL have port done16, output, 1 bit: one-cycle result-valid pulse.
REQ-009 The block SHALL have port diff16, output, 16 bits: difference a16 - b16 - bin16 (mod 2^16).
REQ-010 The block SHALL have port borrow16, output, 1 bit: unsigned borrow-out.
REQ-011 The block SHALL have port ovf16, output, 1 bit: signed overflow; this port exists only when SUB16_OVERFLOW_EN is defined.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-013 In IDLE or DONE, start16 sampled high at a rising edge SHALL latch a16, b16 and bin16, clear the nibble index to 0 and move the FSM to CALC.
REQ-014 In CALC, each rising edge SHALL compute one 4-bit nibble (index 0 to 3, LSB first) as a + ~b + carry, with the initial carry equal to ~bin16 and each later carry equal to the previous nibble's carry-out.
REQ-015 The 4-bit slice and nibble index SHALL wrap: after index 3 is processed, the FSM SHALL move to DONE.
REQ-016 Latency SHALL be fixed: for start accepted at edge N, diff16, borrow16 (and ovf16) SHALL be final and done16=1 in the cycle following edge N+4.
REQ-017 done16 SHALL be high only while in DONE, which lasts exactly one cycle unless a new start is accepted at that edge.
REQ-018 borrow16 SHALL equal the inverted final carry-out, i.e. 1 exactly when a16 < b16 + bin16 (unsigned).
REQ-019 busy16 SHALL be 1 exactly while the FSM is in CALC.
REQ-020 start16 while busy16=1 SHALL be ignored, with operands and progress unchanged.
REQ-021 Input operands SHALL be sampled only at acceptance; changes to a16, b16 or bin16 during CALC SHALL have no effect.
REQ-022 diff16, borrow16 and ovf16 SHALL hold their last completed values until the next accepted start.
REQ-023 Partial results SHALL NOT be required to be stable during CALC.

Reset
REQ-024 Assertion of rst SHALL asynchronously force IDLE, nibble index 0, busy16=0, done16=0, diff16=16'h0000, borrow16=0, ovf16=0 and clear all latched operands.
REQ-025 rst asserted mid-CALC SHALL abort the operation without producing done16.
REQ-026 After rst deasserts, the first start16 SHALL be accepted normally.

Configuration
REQ-027 With SUB16_OVERFLOW_EN defined, ovf16 SHALL be present and SHALL equal 1 exactly when a[15] != b[15] and diff[15] != a[15], evaluated on the latched operands when nibble 3 completes.
REQ-028 Without SUB16_OVERFLOW_EN, the ovf16 port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-029 The bench SHALL check: a16=0x1234, b16=0x0234, bin16=0 -> done16 in the cycle after edge N+4, diff16=0x1000, borrow16=0.
REQ-030 The bench SHALL check: a16=0x0000, b16=0x0001, bin16=0 -> diff16=0xFFFF, borrow16=1, ovf16=0.
REQ-031 The bench SHALL check: a16=0x0005, b16=0x0005, bin16=1 -> diff16=0xFFFF, borrow16=1.
REQ-032 The bench SHALL check: a16=0x8000, b16=0x0001, bin16=0 -> diff16=0x7FFF, borrow16=0, ovf16=1 (port checked only with SUB16_OVERFLOW_EN).
REQ-033 The bench SHALL check: start16 pulsed again at edge N+2 with different operands -> ignored; the first result is delivered unchanged; busy16 stays high through edge N+4.
REQ-034 The bench SHALL check: rst pulsed at edge N+2 -> busy16=0, done16 never asserts, outputs read 0; a following start with 0xFFFF-0x0001 -> diff16=0xFFFE, borrow16=0.
